// File: rtl/spi_xfer_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// spi_xfer_ctrl_pkg: state encoding and parameter legality helpers. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package spi_xfer_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_SETUP = 4'b0010,
    ST_SHIFT = 4'b0100,
    ST_HOLD  = 4'b1000
  } state_t;

  function automatic bit div_legal(input int div);
    return (div >= 2) && ((div % 2) == 0);
  endfunction

  function automatic bit width_legal(input int width);
    return width >= 2;
  endfunction

  // A counter for n states never needs fewer than one bit.
  function automatic int cnt_bits(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_xfer_ctrl_if.sv
// ----------------------------------------------------------------------------
// spi_xfer_ctrl_if: request/response and serial pins of the SPI master. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface spi_xfer_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start_i;
  logic [WIDTH-1:0] data_i;
  logic             ready_o;
  logic             done_o;
  logic [WIDTH-1:0] data_o;
  logic             sclk_o;
  logic             mosi_o;
  logic             miso_i;
  logic             cs_no;

  modport master (
    output start_i, data_i, miso_i,
    input  ready_o, done_o, data_o, sclk_o, mosi_o, cs_no
  );

  modport slave (
    input  start_i, data_i, miso_i,
    output ready_o, done_o, data_o, sclk_o, mosi_o, cs_no
  );
endinterface

`default_nettype wire

// File: rtl/spi_xfer_ctrl_tick.sv
// ----------------------------------------------------------------------------
// spi_tick: strobe every HALF enabled cycles, restartable from zero. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module spi_tick
  import spi_xfer_ctrl_pkg::*;
#(
  parameter int HALF = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic restart,
  input  logic enable,
  output logic tick
);

  localparam int            CW   = cnt_bits(HALF);
  localparam logic [CW-1:0] LAST = CW'(HALF - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = enable && (cnt == LAST);

endmodule

`default_nettype wire

// File: rtl/spi_xfer_ctrl.sv
// ----------------------------------------------------------------------------
// spi_xfer_ctrl: SPI master, one WIDTH-bit MSB-first transfer per start. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module spi_xfer_ctrl
  import spi_xfer_ctrl_pkg::*;
#(
  parameter int DIV       = 8,
  parameter int WIDTH     = 8,
  parameter bit IDLE_HIGH = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  spi_xfer_ctrl_if.slave  bus
);

  localparam int            HALF      = DIV / 2;
  localparam int            EW        = $clog2(2 * WIDTH) + 1;
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * WIDTH - 1);
  localparam logic [EW-1:0] EDGE_MAX  = '1;
  localparam logic          IDLE_LVL  = IDLE_HIGH;

  generate
    if (!div_legal(DIV)) begin : g_bad_div
      $error("spi_xfer_ctrl: DIV must be even and >= 2");
    end
    if (!width_legal(WIDTH)) begin : g_bad_width
      $error("spi_xfer_ctrl: WIDTH must be >= 2");
    end
  endgenerate

  // Asynchronous assert, two-flop synchronous release.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rst_sync <= 2'b00;
    else         rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  state_t           state, state_nx;
  logic             accept, edge_stb, tick, leading;
  logic [EW-1:0]    edge_cnt;
  logic [WIDTH-2:0] tx_rest;
  logic [WIDTH-1:0] rx_sr;
  logic             sclk, mosi, cs_n, ready, done;
  logic [WIDTH-1:0] data_out;

  spi_tick #(.HALF(HALF)) u_tick (
    .clk_i   (clk_i),
    .rst_ni  (rst_n),
    .restart (accept),
    .enable  (state != ST_IDLE),
    .tick    (tick)
  );

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = ST_IDLE;
    accept   = 1'b0;
    edge_stb = 1'b0;
    case (state)
      ST_IDLE: begin
        state_nx = ST_IDLE;
        if (bus.start_i) begin
          accept   = 1'b1;
          state_nx = ST_SETUP;
        end
      end
      ST_SETUP: state_nx = tick ? ST_SHIFT : ST_SETUP;
      ST_SHIFT: begin
        state_nx = ST_SHIFT;
        if (tick) begin
          edge_stb = 1'b1;
          if (edge_cnt == LAST_EDGE) state_nx = ST_HOLD;
        end
      end
      ST_HOLD:  state_nx = tick ? ST_IDLE : ST_HOLD;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Even edge counts precede a leading edge, odd ones a trailing edge.
  assign leading = ~edge_cnt[0];

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt <= '0;
      tx_rest  <= '0;
      rx_sr    <= '0;
      sclk     <= IDLE_LVL;
      mosi     <= 1'b0;
      cs_n     <= 1'b1;
      ready    <= 1'b1;
      done     <= 1'b0;
      data_out <= '0;
    end else begin
      done  <= 1'b0;
      ready <= (state_nx == ST_IDLE);
      cs_n  <= (state_nx == ST_IDLE);
      if (accept) begin
        tx_rest  <= bus.data_i[WIDTH-2:0];
        mosi     <= bus.data_i[WIDTH-1];
        edge_cnt <= '0;
      end
      if (edge_stb) begin
        sclk <= ~sclk;
        if (edge_cnt != EDGE_MAX) edge_cnt <= edge_cnt + 1'b1;
        if (leading) begin
          rx_sr <= {rx_sr[WIDTH-2:0], bus.miso_i};
        end else if (edge_cnt != LAST_EDGE) begin
          mosi    <= tx_rest[WIDTH-2];
          tx_rest <= tx_rest << 1;
        end
      end else if (state_nx == ST_IDLE) begin
        sclk <= IDLE_LVL;
      end
      if ((state == ST_HOLD) && tick) begin
        done     <= 1'b1;
        data_out <= rx_sr;
      end
    end
  end

  assign bus.ready_o = ready;
  assign bus.done_o  = done;
  assign bus.data_o  = data_out;
  assign bus.sclk_o  = sclk;
  assign bus.mosi_o  = mosi;
  assign bus.cs_no   = cs_n;

endmodule

`default_nettype wire

// File: tb/tb_spi_xfer_ctrl.sv
// ----------------------------------------------------------------------------
// tb_spi_xfer_ctrl: scoreboard bench for two SPI master configurations. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_spi_xfer_ctrl;

  localparam int W    = 8;
  localparam int NDUT = 2;
  localparam int DIV0 = 8;
  localparam int DIV1 = 2;

  typedef struct {
    int           dut;
    logic [W-1:0] tx;
    logic [W-1:0] rx;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  exp_t sbq[$];

  logic [NDUT-1:0] start_a = '0;
  logic [NDUT-1:0] loop_a  = '1;
  logic [NDUT-1:0] drv_a   = '0;
  logic [W-1:0]    din_a  [NDUT];
  logic [W-1:0]    rxw_a  [NDUT];
  logic [NDUT-1:0] ready_a, done_a, sclk_a, mosi_a, cs_a;
  logic [W-1:0]    dout_a [NDUT];

  spi_xfer_ctrl_if #(.WIDTH(W)) bus0 ();
  spi_xfer_ctrl_if #(.WIDTH(W)) bus1 ();

  spi_xfer_ctrl #(.DIV(DIV0), .WIDTH(W), .IDLE_HIGH(1'b1)) u_dut0 (
    .clk_i (clk), .rst_ni (rst_n), .bus (bus0.slave)
  );
  spi_xfer_ctrl #(.DIV(DIV1), .WIDTH(W), .IDLE_HIGH(1'b0)) u_dut1 (
    .clk_i (clk), .rst_ni (rst_n), .bus (bus1.slave)
  );

  assign bus0.start_i = start_a[0];
  assign bus0.data_i  = din_a[0];
  assign bus0.miso_i  = loop_a[0] ? bus0.mosi_o : drv_a[0];
  assign bus1.start_i = start_a[1];
  assign bus1.data_i  = din_a[1];
  assign bus1.miso_i  = loop_a[1] ? bus1.mosi_o : drv_a[1];

  assign ready_a = {bus1.ready_o, bus0.ready_o};
  assign done_a  = {bus1.done_o,  bus0.done_o};
  assign sclk_a  = {bus1.sclk_o,  bus0.sclk_o};
  assign mosi_a  = {bus1.mosi_o,  bus0.mosi_o};
  assign cs_a    = {bus1.cs_no,   bus0.cs_no};
  assign dout_a[0] = bus0.data_o;
  assign dout_a[1] = bus1.data_o;

  function automatic int half_of(input int k);
    return (k == 0) ? DIV0 / 2 : DIV1 / 2;
  endfunction

  function automatic logic idle_of(input int k);
    return (k == 0) ? 1'b1 : 1'b0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: per-transfer observation of the serial pins, scored at done_o.
  int           cs_low [NDUT];
  int           run    [NDUT];
  int           pulses [NDUT];
  int           trail  [NDUT];
  int           done_cnt [NDUT];
  logic         prev   [NDUT];
  logic [W-1:0] mtx    [NDUT];

  initial begin
    for (int k = 0; k < NDUT; k++) begin
      cs_low[k] = 0; run[k] = 0; pulses[k] = 0; trail[k] = 0;
      done_cnt[k] = 0; prev[k] = idle_of(k); mtx[k] = '0;
      din_a[k] = '0; rxw_a[k] = '0;
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < NDUT; k++) begin
      if (!rst_n) begin
        cs_low[k] = 0; run[k] = 0; pulses[k] = 0; trail[k] = 0;
        prev[k] = idle_of(k); mtx[k] = '0;
      end else begin
        if (!cs_a[k]) begin
          cs_low[k]++;
          if (sclk_a[k] != idle_of(k)) begin
            if (prev[k] == idle_of(k)) mtx[k] = {mtx[k][W-2:0], mosi_a[k]};
            run[k]++;
          end else if (prev[k] != idle_of(k)) begin
            check("sclk_active_width", run[k], half_of(k));
            pulses[k]++;
            trail[k]++;
            run[k] = 0;
          end
        end else begin
          trail[k] = 0;
        end
        prev[k]  = sclk_a[k];
        drv_a[k] = rxw_a[k][(trail[k] < W) ? (W - 1 - trail[k]) : 0];
        if (done_a[k]) begin
          done_cnt[k]++;
          if (sbq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_done: dut%0d got done_o=1, expected none", k);
          end else begin
            exp_t e;
            e = sbq.pop_front();
            check("done_dut", k, e.dut);
            check("data_o", dout_a[k], e.rx);
            check("mosi_bits", mtx[k], e.tx);
            check("cs_low_cycles", cs_low[k], (2 * W + 2) * half_of(k));
            check("sclk_pulses", pulses[k], W);
            check("cs_at_done", cs_a[k], 1);
            check("ready_at_done", ready_a[k], 1);
            check("sclk_idle_at_done", sclk_a[k], idle_of(k));
          end
          cs_low[k] = 0; run[k] = 0; pulses[k] = 0; mtx[k] = '0;
        end
      end
    end
  end

  task automatic issue(input int k, input logic [W-1:0] tx, input logic lp, input logic [W-1:0] rx);
    int t;
    exp_t e;
    t = 0;
    @(negedge clk);
    while (!ready_a[k] && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("ready_before_issue", ready_a[k], 1);
    din_a[k]  = tx;
    loop_a[k] = lp;
    rxw_a[k]  = rx;
    start_a[k] = 1'b1;
    e.dut = k;
    e.tx  = tx;
    e.rx  = lp ? tx : rx;
    sbq.push_back(e);
    @(posedge clk);
    #1 start_a[k] = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sbq.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("drain_queue_size", sbq.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic reset_checks(input string tag);
    for (int k = 0; k < NDUT; k++) begin
      check({tag, "_cs"},    cs_a[k],    1);
      check({tag, "_sclk"},  sclk_a[k],  idle_of(k));
      check({tag, "_ready"}, ready_a[k], 1);
      check({tag, "_done"},  done_a[k],  0);
      check({tag, "_data"},  dout_a[k],  0);
      check({tag, "_mosi"},  mosi_a[k],  0);
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int base, n, t;
    logic [W-1:0] v;

    #1 rst_n = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset_checks("reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Loopback of 0xA5 and an externally driven 0x3C.
    issue(0, 8'hA5, 1'b1, 8'h00);
    drain();
    issue(0, $urandom, 1'b0, 8'h3C);
    drain();

    for (int i = 0; i < 8; i++) begin
      issue(0, W'($urandom), 1'($urandom), W'($urandom));
      drain();
    end

    // start_i held across three transfers: one-cycle chip-select gaps.
    base = done_cnt[0];
    v = W'($urandom);
    @(negedge clk);
    din_a[0] = v; loop_a[0] = 1'b1; start_a[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_t e;
      e.dut = 0; e.tx = v; e.rx = v;
      sbq.push_back(e);
    end
    n = 0;
    t = 0;
    while (n < 3 && t < 1000) begin
      @(negedge clk);
      t++;
      if (done_a[0]) begin
        n++;
        if (n < 3) begin
          @(negedge clk);
          check("cs_gap_one_cycle", cs_a[0], 0);
          if (n == 2) start_a[0] = 1'b0;
        end
      end
    end
    start_a[0] = 1'b0;
    check("held_start_dones", n, 3);
    repeat (10) @(negedge clk);
    check("held_start_stops", cs_a[0], 1);
    drain();

    // A start pulse mid-SHIFT must be ignored.
    base = done_cnt[0];
    v = W'($urandom);
    issue(0, v, 1'b1, 8'h00);
    repeat (30) @(negedge clk);
    din_a[0] = ~v;
    start_a[0] = 1'b1;
    @(negedge clk);
    start_a[0] = 1'b0;
    drain();
    repeat (100) @(negedge clk);
    check("midshift_done_count", done_cnt[0] - base, 1);

    // Reset 20 cycles into a transfer aborts it immediately.
    base = done_cnt[0];
    issue(0, W'($urandom), 1'b1, 8'h00);
    repeat (19) @(posedge clk);
    #2 rst_n = 1'b0;
    void'(sbq.pop_back());
    #1;
    reset_checks("abort");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("abort_no_done", done_cnt[0] - base, 0);
    check("abort_data_cleared", dout_a[0], 0);
    issue(0, 8'h0F, 1'b1, 8'h00);
    drain();

    // Fast divider, idle-low clock.
    for (int i = 0; i < 5; i++) begin
      issue(1, W'($urandom), 1'($urandom), W'($urandom));
      drain();
    end

    check("final_queue_empty", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
